// File: rtl/fp_add_seq_pkg.sv
// Shared definitions for the sequential FP32 adder/subtractor: field
// widths, special-value constants and the controller state encoding.
package fp_add_seq_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_INC,
        S_NORM,
        S_OUT
    } state_t;

endpackage

// File: rtl/adder_24bit.sv
// 24-bit ripple-carry adder with carry in and carry out. This is the
// single arithmetic resource that fp_add_seq time-shares.
module adder_24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] sum,
    output logic        cout
);

    logic [24:0] carry;

    // Ripple chain: one full adder per bit, LSB first.
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < 24; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[24];
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle FP32 adder/subtractor. One shared adder_24bit, single-bit
// shifters, truncating rounding, denormals flushed to zero.
// Optional exception flags output is enabled by defining FP_ADD_SEQ_FLAGS_EN.
module fp_add_seq
    import fp_add_seq_pkg::*;
#(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
`ifdef FP_ADD_SEQ_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic [EXP_W-1:0] MAX_D = EXP_W'(MAX_ALIGN);

    state_t            state;
    logic [31:0]       a_r, b_r;
    logic              sub_r;
    logic              sign_l, eff_sub, carry_r;
    logic [EXP_W-1:0]  exp_r, align_cnt;
    logic [MAN_W:0]    man_l, man_s, sum_r;

    // Unpack view of the registered operands.
    logic              a_sign, b_sign, l_sign, s_sign, swap, special;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [30:0]       a_mag, b_mag, l_mag, s_mag;
    logic [EXP_W-1:0]  exp_diff, d_val;
    logic [MAN_W:0]    l_man, s_man;
    logic [31:0]       special_res;

    // Shared adder ports and post-add decision.
    logic [MAN_W:0]    add_a, add_b, add_sum;
    logic              add_cin, add_cout, post_carry, post_done;
    logic [31:0]       post_res;

    // Normalisation step candidates.
    logic [EXP_W-1:0]  exp_up, exp_dn;
    logic [MAN_W:0]    sum_shl;

    // Field split, denormal flush, magnitude ordering and special-case result.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        a_sign   = a_r[31];
        b_sign   = b_r[31] ^ sub_r;
        a_zero   = (a_r[30:23] == '0);
        b_zero   = (b_r[30:23] == '0);
        a_nan    = (&a_r[30:23]) && (|a_r[22:0]);
        b_nan    = (&b_r[30:23]) && (|b_r[22:0]);
        a_inf    = (&a_r[30:23]) && !(|a_r[22:0]);
        b_inf    = (&b_r[30:23]) && !(|b_r[22:0]);
        a_mag    = a_zero ? '0 : a_r[30:0];
        b_mag    = b_zero ? '0 : b_r[30:0];
        swap     = (b_mag > a_mag);
        l_mag    = swap ? b_mag : a_mag;
        s_mag    = swap ? a_mag : b_mag;
        l_sign   = swap ? b_sign : a_sign;
        s_sign   = swap ? a_sign : b_sign;
        l_man    = {|l_mag[30:23], l_mag[22:0]};
        s_man    = {|s_mag[30:23], s_mag[22:0]};
        exp_diff = l_mag[30:23] - s_mag[30:23];
        d_val    = (exp_diff >= MAX_D) ? MAX_D : exp_diff;

        special     = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
            special_res = QNAN;
        else if (a_inf)
            special_res = {a_sign, PINF[30:0]};
        else if (b_inf)
            special_res = {b_sign, PINF[30:0]};
        else if (a_zero && b_zero)
            special_res = {a_sign & b_sign, 31'd0};
        else
            special = 1'b0;
    end

    // Adder operand mux: live only in ADD and INC, parked at zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == S_ADD) begin
            add_a = man_l;
            add_b = eff_sub ? ~man_s : man_s;
        end else if (state == S_INC) begin
            add_a   = sum_r;
            add_cin = 1'b1;
        end
    end

    adder_24bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Decide whether the fresh sum is already final, and the normalise candidates.
    always_comb begin
        post_carry = (state == S_ADD) && !eff_sub && add_cout;
        post_done  = !post_carry && ((add_sum == '0) || add_sum[MAN_W]);
        post_res   = (add_sum == '0) ? 32'd0 : {sign_l, exp_r, add_sum[MAN_W-1:0]};
        exp_up     = exp_r + 1'b1;
        exp_dn     = exp_r - 1'b1;
        sum_shl    = {sum_r[MAN_W-1:0], 1'b0};
    end

    // Controller FSM with registered handshake outputs and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            sign_l    <= 1'b0;
            eff_sub   <= 1'b0;
            carry_r   <= 1'b0;
            exp_r     <= '0;
            align_cnt <= '0;
            man_l     <= '0;
            man_s     <= '0;
            sum_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= op_a;
                        b_r      <= op_b;
                        sub_r    <= sub;
                        in_ready <= 1'b0;
                        state    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (special) begin
                        result    <= special_res;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        sign_l    <= l_sign;
                        eff_sub   <= (l_sign != s_sign);
                        exp_r     <= l_mag[30:23];
                        man_l     <= l_man;
                        man_s     <= s_man;
                        align_cnt <= d_val;
                        state     <= (d_val == '0) ? S_ADD : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (align_cnt == MAX_D) begin
                        man_s <= '0;
                        state <= S_ADD;
                    end else begin
                        man_s     <= man_s >> 1;
                        align_cnt <= align_cnt - 1'b1;
                        if (align_cnt == 8'd1)
                            state <= S_ADD;
                    end
                end
                S_ADD, S_INC: begin
                    sum_r   <= add_sum;
                    carry_r <= post_carry;
                    if (state == S_ADD && eff_sub) begin
                        state <= S_INC;
                    end else if (post_done) begin
                        result    <= post_res;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (carry_r) begin
                        carry_r   <= 1'b0;
                        result    <= (exp_up == 8'hFF) ? {sign_l, PINF[30:0]}
                                                       : {sign_l, exp_up, sum_r[MAN_W:1]};
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (exp_dn == '0) begin
                        result    <= {sign_l, 31'd0};
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        sum_r <= sum_shl;
                        exp_r <= exp_dn;
                        if (sum_shl[MAN_W]) begin
                            result    <= {sign_l, exp_dn, sum_shl[MAN_W-1:0]};
                            out_valid <= 1'b1;
                            state     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FP_ADD_SEQ_FLAGS_EN
    // Exception flags {invalid, overflow, underflow, inexact}: cleared on acceptance, sticky until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            case (state)
                S_IDLE:   if (in_valid && in_ready) flags <= '0;
                S_UNPACK: if (special && special_res == QNAN) flags[3] <= 1'b1;
                S_ALIGN: begin
                    if ((align_cnt == MAX_D) ? (man_s != '0) : man_s[0])
                        flags[0] <= 1'b1;
                end
                S_NORM: begin
                    if (carry_r) begin
                        if (sum_r[0])        flags[0] <= 1'b1;
                        if (exp_up == 8'hFF) flags[2] <= 1'b1;
                    end else if (exp_dn == '0) begin
                        flags[1] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed cases with hand-computed
// results, then randomized operands checked against a behavioural model.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
`ifdef FP_ADD_SEQ_FLAGS_EN
    logic [3:0]  flags;
`endif

    always #5 clk = ~clk;

    fp_add_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef FP_ADD_SEQ_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: exact integer arithmetic on the IEEE fields, truncating, denormals flushed.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] r, output int lat);
        logic   sa, sb, sl, ss, a_nan, b_nan, a_inf, b_inf, done;
        int     ea, eb, el, es, diff, e;
        longint ml, ms, sum;
        logic [30:0] mag_a, mag_b;
        sa = a[31];
        sb = b[31] ^ s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        lat = 1;
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) begin r = 32'h7FC00000; return; end
        if (a_inf) begin r = {sa, 31'h7F800000}; return; end
        if (b_inf) begin r = {sb, 31'h7F800000}; return; end
        if (ea == 0 && eb == 0) begin r = {sa & sb, 31'd0}; return; end
        mag_a = (ea == 0) ? 31'd0 : a[30:0];
        mag_b = (eb == 0) ? 31'd0 : b[30:0];
        if (mag_b > mag_a) begin
            sl = sb; el = eb; ml = longint'(b[22:0]) + 64'h800000;
            ss = sa; es = ea; ms = (ea == 0) ? 0 : longint'(a[22:0]) + 64'h800000;
        end else begin
            sl = sa; el = ea; ml = longint'(a[22:0]) + 64'h800000;
            ss = sb; es = eb; ms = (eb == 0) ? 0 : longint'(b[22:0]) + 64'h800000;
        end
        diff = el - es;
        if (diff >= 25) begin ms = 0; lat = 3; end
        else begin ms = ms >> diff; lat = 2 + diff; end
        if (sl != ss) begin sum = ml - ms; lat++; end
        else sum = ml + ms;
        e = el;
        if (sum == 0) begin
            r = 32'd0;
        end else if (sum >= 64'h1000000) begin
            sum = sum >> 1; e++; lat++;
            r = (e == 255) ? {sl, 31'h7F800000} : {sl, 8'(e), 23'(sum)};
        end else begin
            done = 1'b0;
            while (sum < 64'h800000 && !done) begin
                sum = sum << 1; e--; lat++;
                if (e == 0) done = 1'b1;
            end
            r = (e == 0) ? {sl, 31'd0} : {sl, 8'(e), 23'(sum)};
        end
    endfunction

    // Compare process: checks result, latency and in_ready on every cycle out_valid is high.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: out_valid=1 with no outstanding operation (cycle %0d)", cyc);
                end else begin
                    check("result", result, q[0].res);
                    if (!prev_valid) check("latency", cyc - q[0].acc, q[0].lat);
                    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input int lat);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
            return;
        end
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        q.push_back('{res: r, lat: lat, acc: cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] r;
        int          lat;
        model(a, b, s, r, lat);
        send(a, b, s, r, lat);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL done_timeout: %0d results still outstanding", q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] rand_fp(input logic [31:0] near);
        logic [31:0] sp [6];
        int          sel, ex;
        sp = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000000, 32'h80000000, 32'h00000123};
        sel = int'($urandom_range(0, 15));
        if (sel == 0) return sp[$urandom_range(0, 5)];
        if (sel <= 5) begin
            ex = int'(near[30:23]) + int'($urandom_range(0, 6)) - 3;
            if (ex < 1) ex = 1;
            if (ex > 254) ex = 254;
            return {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
        end
        if (sel <= 7) return {1'($urandom_range(0, 1)), near[30:0] ^ 31'($urandom_range(0, 255))};
        if (sel == 8) return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 4)), 23'($urandom)};
        if (sel == 9) return {1'($urandom_range(0, 1)), 8'($urandom_range(250, 254)), 23'($urandom)};
        return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b;
        int          lat, n;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_result", result, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Pin the model with hand-derived values.
        model(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
        check("model_1p1", r, 32'h40000000);
        check("model_1p1_lat", lat, 32'd3);
        model(32'h40400000, 32'h3F000000, 1'b0, r, lat);
        check("model_3p05", r, 32'h40600000);
        check("model_3p05_lat", lat, 32'd4);
        model(32'h00800001, 32'h00800000, 1'b1, r, lat);
        check("model_uflow", r, 32'h00000000);
        check("model_uflow_lat", lat, 32'd4);

        // Directed operations with literal expectations.
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3);  wait_done();
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3);  wait_done();
        send(32'h40400000, 32'h3F000000, 1'b0, 32'h40600000, 4);  wait_done();
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1);  wait_done();
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3);  wait_done();
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1);  wait_done();
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1);  wait_done();
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1);  wait_done();
        send(32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 1);  wait_done();
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4);  wait_done();
        send(32'hC0400000, 32'h3F000000, 1'b1, 32'hC0600000, 4);  wait_done();

        // Backpressure: result held, busy, extra request ignored.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        op_a = 32'h40400000; op_b = 32'h3F000000; sub = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("bp_idle_after", {31'd0, in_ready}, 32'd1);

        // Reset pulse during alignment aborts the operation.
        send(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 25);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        send(32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 25);
        wait_done();

        // Randomized operands against the model, with random consumer stalls.
        rand_ready = 1'b1;
        a = 32'h3F800000;
        for (int i = 0; i < 300; i++) begin
            a = rand_fp(a);
            b = rand_fp(a);
            send_model(a, b, 1'($urandom_range(0, 1)));
        end
        wait_done();
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
